// File: rtl/fft_r2_engine.sv
// In-place radix-2 DIT FFT/IFFT engine: streaming bit-reversed load, LOG2N butterfly
// passes against an external 1-cycle twiddle ROM, natural-order unload. FFT_OVF_DETECT_EN adds ovf_o.
module fft_r2_engine #(
  parameter int N    = 1024,
  parameter int DW   = 32,
  parameter int TW_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   inverse_i,
  input  logic                   scale_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [DW-1:0]   in_re_i,
  input  logic signed [DW-1:0]   in_im_i,
  output logic [$clog2(N)-2:0]   tw_addr_o,
  input  logic signed [TW_W-1:0] tw_re_i,
  input  logic signed [TW_W-1:0] tw_im_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic signed [DW-1:0]   out_re_o,
  output logic signed [DW-1:0]   out_im_o,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef FFT_OVF_DETECT_EN
  output logic                   ovf_o,
`endif
  output logic [2:0]             state_o
);
  localparam int LOG2N  = $clog2(N);
  localparam int HALF   = N / 2;
  localparam int BF_LAT = 3;
  localparam int CW     = LOG2N + 1;
  localparam int MW     = DW + TW_W;
  localparam int PW     = MW + 1;
  localparam int AW     = PW + 1;
  localparam logic signed [TW_W-1:0] TW_MIN = {1'b1, {(TW_W-1){1'b0}}};
  localparam logic signed [TW_W-1:0] TW_MAX = {1'b0, {(TW_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_COMP = 3'd2,
    S_UNLD = 3'd3
  } state_t;

  state_t             r_state, w_next;
  logic               r_inv, r_scale, r_done;
  logic [LOG2N-1:0]   r_idx, r_stage;
  logic [CW-1:0]      r_cnt;
  logic [BF_LAT-1:1]  r_vld_pipe;
  logic               w_in_xfer, w_out_xfer, w_issue, w_stage_end;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  logic signed [DW-1:0]   r1_ar, r1_ai, r1_br, r1_bi, r2_ar, r2_ai, r2_br, r2_bi;
  logic [LOG2N-1:0]       r1_aa, r1_ab, r2_aa, r2_ab;
  logic signed [TW_W-1:0] r2_wr, r2_wi;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] v);
    for (int i = 0; i < LOG2N; i++) f_bitrev[i] = v[LOG2N-1-i];
  endfunction

  // Butterfly j of stage s: a = (j>>s)*2^(s+1) + (j mod 2^s), b = a + 2^s.
  logic [LOG2N-1:0] w_jx, w_half, w_k, w_a, w_b;
  logic [LOG2N-2:0] w_tw;
  always_comb begin
    w_jx        = {1'b0, r_cnt[LOG2N-2:0]};
    w_half      = LOG2N'(1) << r_stage;
    w_k         = w_jx & (w_half - LOG2N'(1));
    w_a         = ((w_jx >> r_stage) << (r_stage + LOG2N'(1))) | w_k;
    w_b         = w_a | w_half;
    w_tw        = (LOG2N-1)'(w_k << (LOG2N'(LOG2N - 1) - r_stage));
    w_issue     = (r_state == S_COMP) && (r_cnt < CW'(HALF));
    w_stage_end = (r_state == S_COMP) && (r_cnt == CW'(HALF + BF_LAT - 1));
  end

  logic signed [TW_W-1:0] w_tw_im;
  logic signed [MW-1:0]   w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [PW-1:0]   w_t_re, w_t_im;
  logic signed [AW-1:0]   w_sa_re, w_sa_im, w_sb_re, w_sb_im;
  logic signed [DW-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
  always_comb begin
    // Conjugating the most negative twiddle word saturates instead of wrapping.
    w_tw_im = tw_im_i;
    if (r_inv) w_tw_im = (tw_im_i == TW_MIN) ? TW_MAX : -tw_im_i;
    w_p_rr  = MW'(r2_br) * MW'(r2_wr);
    w_p_ii  = MW'(r2_bi) * MW'(r2_wi);
    w_p_ri  = MW'(r2_br) * MW'(r2_wi);
    w_p_ir  = MW'(r2_bi) * MW'(r2_wr);
    w_t_re  = (PW'(w_p_rr) - PW'(w_p_ii)) >>> (TW_W - 2);
    w_t_im  = (PW'(w_p_ri) + PW'(w_p_ir)) >>> (TW_W - 2);
    w_sa_re = AW'(r2_ar) + AW'(w_t_re);
    w_sa_im = AW'(r2_ai) + AW'(w_t_im);
    w_sb_re = AW'(r2_ar) - AW'(w_t_re);
    w_sb_im = AW'(r2_ai) - AW'(w_t_im);
    w_a_re  = DW'(r_scale ? (w_sa_re >>> 1) : w_sa_re);
    w_a_im  = DW'(r_scale ? (w_sa_im >>> 1) : w_sa_im);
    w_b_re  = DW'(r_scale ? (w_sb_re >>> 1) : w_sb_re);
    w_b_im  = DW'(r_scale ? (w_sb_im >>> 1) : w_sb_im);
  end

  // Sample memory and butterfly pipeline; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      mem_re[f_bitrev(r_idx)] <= in_re_i;
      mem_im[f_bitrev(r_idx)] <= in_im_i;
    end
    if (r_vld_pipe[BF_LAT-1]) begin
      mem_re[r2_aa] <= w_a_re;
      mem_im[r2_aa] <= w_a_im;
      mem_re[r2_ab] <= w_b_re;
      mem_im[r2_ab] <= w_b_im;
    end
    r1_ar <= mem_re[w_a];
    r1_ai <= mem_im[w_a];
    r1_br <= mem_re[w_b];
    r1_bi <= mem_im[w_b];
    r1_aa <= w_a;
    r1_ab <= w_b;
    r2_ar <= r1_ar;
    r2_ai <= r1_ai;
    r2_br <= r1_br;
    r2_bi <= r1_bi;
    r2_aa <= r1_aa;
    r2_ab <= r1_ab;
    r2_wr <= tw_re_i;
    r2_wi <= w_tw_im;
  end

  always_comb begin
    w_next      = r_state;
    w_in_xfer   = 1'b0;
    w_out_xfer  = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_re_o    = '0;
    out_im_o    = '0;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_LOAD;
      S_LOAD: begin
        in_ready_o = 1'b1;
        w_in_xfer  = in_valid_i;
        if (in_valid_i && r_idx == LOG2N'(N - 1)) w_next = S_COMP;
      end
      S_COMP: if (w_stage_end && r_stage == LOG2N'(LOG2N - 1)) w_next = S_UNLD;
      S_UNLD: begin
        out_valid_o = 1'b1;
        out_last_o  = (r_idx == LOG2N'(N - 1));
        out_re_o    = mem_re[r_idx];
        out_im_o    = mem_im[r_idx];
        w_out_xfer  = out_ready_i;
        if (out_ready_i && out_last_o) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_inv      <= 1'b0;
      r_scale    <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_stage    <= '0;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_out_xfer && out_last_o;
      r_vld_pipe <= {r_vld_pipe[BF_LAT-2:1], w_issue};
      if (r_state == S_IDLE && start_i) begin
        r_inv   <= inverse_i;
        r_scale <= scale_i;
        r_idx   <= '0;
        r_stage <= '0;
        r_cnt   <= '0;
      end
      // One index serves both load order and unload bin; it wraps to 0 after N-1.
      if (w_in_xfer || w_out_xfer) r_idx <= r_idx + LOG2N'(1);
      if (r_state == S_COMP) begin
        if (w_stage_end) begin
          r_cnt   <= '0;
          r_stage <= (w_next == S_UNLD) ? '0 : r_stage + LOG2N'(1);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign state_o   = r_state;
  assign done_o    = r_done;
  assign tw_addr_o = w_issue ? w_tw : '0;

`ifdef FFT_OVF_DETECT_EN
  // Overflow: the pre-scale result differs from its own DW-bit sign-extended truncation.
  function automatic logic f_ovf(input logic signed [AW-1:0] v);
    return v != AW'($signed(DW'(v)));
  endfunction

  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (r_state == S_IDLE && start_i)
      r_ovf <= 1'b0;
    else if (r_vld_pipe[BF_LAT-1] &&
             (f_ovf(w_sa_re) || f_ovf(w_sa_im) || f_ovf(w_sb_re) || f_ovf(w_sb_im)))
      r_ovf <= 1'b1;
  end
  assign ovf_o = r_ovf;
`endif
endmodule
